sim_status_reporter: RTL

- DUT-side end of the bench pass/fail contract. Sits inside `top` and is the only driver of `passed` and `failed`.
- Consumes a stream of self-check compare events from design logic.
- Tracks the check count, first mismatch and an internal watchdog, then latches a sticky verdict.
- The bench polls the verdict once per cycle and ends the simulation on it.

---
 rtl/sim_status_pkg.sv | 22 ++
 rtl/sim_status_reporter.sv | 114 +++++++++++
 2 files changed

// File: rtl/sim_status_pkg.sv
// sim_status_pkg: shared types for the simulation status reporter.
// Verdict FSM states and the reason codes reported on failure.
package sim_status_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        MISMATCH = 3'd1,
        TIMEOUT  = 3'd2,
        EXT_ERR  = 3'd3,
        TOO_FEW  = 3'd4,
        CNT_OVF  = 3'd5
    } fail_reason_e;

endpackage

// File: rtl/sim_status_reporter.sv
// sim_status_reporter: turns self-check compare events into a sticky
// pass/fail verdict with a reason code, counters and first-mismatch capture.
module sim_status_reporter
    import sim_status_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int MIN_CHECKS     = 1,
    parameter int TIMEOUT_CYCLES = 90,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chk_valid,
    input  logic [DATA_W-1:0] chk_actual,
    input  logic [DATA_W-1:0] chk_expect,
    input  logic              chk_last,
    input  logic              err_in,
    output logic              passed,
    output logic              failed,
    output logic [2:0]        fail_reason,
    output logic [CNT_W-1:0]  chk_cnt,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [DATA_W-1:0] mis_actual,
    output logic [DATA_W-1:0] mis_expect,
    output logic [CNT_W-1:0]  mis_index
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W:0]   MIN_C   = (CNT_W + 1)'(MIN_CHECKS);

    state_e           state;
    state_e           state_nxt;
    fail_reason_e     reason_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cyc_nxt;
    logic             enough;
    logic             capture;

    // Saturating increment and the "enough checks" test, computed one bit wider.
    assign cnt_inc = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + 1'b1;
    assign enough  = ({1'b0, chk_cnt} + 1'b1) >= MIN_C;

    // Next-state, reason and counter update; priority order of RUN decisions.
    always_comb begin
        state_nxt  = state;
        reason_nxt = fail_reason_e'(fail_reason);
        cnt_nxt    = chk_cnt;
        cyc_nxt    = cyc_cnt;
        capture    = 1'b0;
        if (state == RUN) begin
            if (cyc_cnt != CNT_MAX) begin
                cyc_nxt = cyc_cnt + 1'b1;
            end
            if (err_in) begin
                state_nxt  = FAIL;
                reason_nxt = EXT_ERR;
            end else if (chk_valid && (chk_actual != chk_expect)) begin
                state_nxt  = FAIL;
                reason_nxt = MISMATCH;
                capture    = 1'b1;
            end else if (chk_valid && chk_last) begin
                cnt_nxt = cnt_inc;
                if (enough) begin
                    state_nxt = PASS;
                end else begin
                    state_nxt  = FAIL;
                    reason_nxt = TOO_FEW;
                end
            end else if (chk_valid && (chk_cnt == CNT_MAX)) begin
                state_nxt  = FAIL;
                reason_nxt = CNT_OVF;
            end else begin
                // A plain matching check still counts; it must not mask the watchdog.
                if (chk_valid) begin
                    cnt_nxt = cnt_inc;
                end
                if (cyc_cnt == TO_LAST) begin
                    state_nxt  = FAIL;
                    reason_nxt = TIMEOUT;
                end
            end
        end
    end

    // Registered state, verdict, counters and first-mismatch capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            passed      <= 1'b0;
            failed      <= 1'b0;
            fail_reason <= NONE;
            chk_cnt     <= '0;
            cyc_cnt     <= '0;
            mis_actual  <= '0;
            mis_expect  <= '0;
            mis_index   <= '0;
        end else begin
            state       <= state_nxt;
            passed      <= (state_nxt == PASS);
            failed      <= (state_nxt == FAIL);
            fail_reason <= reason_nxt;
            chk_cnt     <= cnt_nxt;
            cyc_cnt     <= cyc_nxt;
            if (capture) begin
                mis_actual <= chk_actual;
                mis_expect <= chk_expect;
                mis_index  <= chk_cnt;
            end
        end
    end

endmodule
